mem_stage: RTL and testbench

MEM_STAGE -- requirements
Module: mem_stage

---
 rtl/mips_pkg.sv | 18 +
 rtl/mem_stage_if.sv | 22 ++
 rtl/mem_stage.sv | 111 +++++++++++
 tb/tb_mem_stage.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared MEM-stage definitions: FSM state encoding, watchdog default and
// the mask used to detect word-misaligned effective addresses.
package mips_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } mem_state_t;

    localparam int unsigned TIMEOUT_DEFAULT = 255;
    localparam logic [31:0] WORD_ALIGN_MASK = 32'h0000_0003;

    function automatic logic is_word_aligned(input logic [31:0] addr);
        return (addr & WORD_ALIGN_MASK) == 32'h0;
    endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Data-memory bus between the MEM stage (master) and the data memory (slave).
interface mem_stage_if;
    import mips_pkg::*;

    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_wdata,
        input  dmem_ack, dmem_rdata
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
        output dmem_ack, dmem_rdata
    );

endinterface

// File: rtl/mem_stage.sv
// MEM pipeline stage: issues one data-bus transfer per load/store, stalls the
// front of the pipeline until ack or watchdog abort, then hands results to MEM/WB.
module mem_stage
    import mips_pkg::*;
#(
    parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic               clk,
    input  logic               nrst,

    input  logic [31:0]        i_ALUOut,
    input  logic [31:0]        i_RTData,
    input  logic               i_MemRead,
    input  logic               i_MemWrite,
    input  logic               i_Mem2Reg,
    input  logic               i_RegWrite,
    input  logic [4:0]         i_RegAddrW,
    input  logic               i_Overflow,

    mem_stage_if.master        dmem,

    output logic               o_stall,
    output logic               o_RegWrite,
    output logic               o_Mem2Reg,
    output logic [4:0]         o_RegAddrW,
    output logic [31:0]        o_ALUOut,
    output logic [31:0]        o_MemData,
    output logic               o_AddrErr,
    output logic               o_BusErr
);

    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

    mem_state_t  state_reg;
    logic [7:0]  cnt_reg;
    logic [31:0] addr_reg;
    logic [31:0] wdata_reg;
    logic        we_reg;
    logic [31:0] memdata_reg;
    logic        buserr_reg;

    logic        mem_access;
    logic        misaligned;
    logic        valid_access;

    assign mem_access   = i_MemRead | i_MemWrite;
    assign misaligned   = mem_access & ~is_word_aligned(i_ALUOut);
    assign valid_access = mem_access & ~i_Overflow & is_word_aligned(i_ALUOut);

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_reg   <= IDLE;
            cnt_reg     <= '0;
            addr_reg    <= '0;
            wdata_reg   <= '0;
            we_reg      <= 1'b0;
            memdata_reg <= '0;
            buserr_reg  <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (valid_access) begin
                        state_reg <= BUSY;
                        addr_reg  <= i_ALUOut;
                        wdata_reg <= i_RTData;
                        we_reg    <= i_MemWrite;
                        cnt_reg   <= '0;
                    end
                end
                BUSY: begin
                    // An ack landing on the timeout cycle still completes normally.
                    if (dmem.dmem_ack) begin
                        state_reg  <= DONE;
                        buserr_reg <= 1'b0;
                        if (!we_reg) begin
                            memdata_reg <= dmem.dmem_rdata;
                        end
                    end else if (cnt_reg == TIMEOUT_LAST) begin
                        state_reg   <= DONE;
                        buserr_reg  <= 1'b1;
                        memdata_reg <= '0;
                    end else begin
                        cnt_reg <= cnt_reg + 8'd1;
                    end
                end
                DONE: begin
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    // Request follows state only, so an asynchronous reset drops it at once.
    assign dmem.dmem_req   = (state_reg == BUSY);
    assign dmem.dmem_we    = we_reg & (state_reg == BUSY);
    assign dmem.dmem_addr  = addr_reg;
    assign dmem.dmem_wdata = wdata_reg;

    assign o_stall    = nrst & (((state_reg == IDLE) & valid_access) | (state_reg == BUSY));
    assign o_BusErr   = buserr_reg & (state_reg == DONE);
    assign o_AddrErr  = misaligned;
    assign o_MemData  = memdata_reg;
    assign o_ALUOut   = i_ALUOut;
    assign o_Mem2Reg  = i_Mem2Reg;
    assign o_RegAddrW = i_RegAddrW;
    assign o_RegWrite = i_RegWrite & ~i_Overflow & ~misaligned & ~(o_BusErr & i_MemRead);

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: inputs change just after the falling edge,
// outputs are checked shortly after, well away from the rising edge.
module tb_mem_stage;
    import mips_pkg::*;

    logic        clk;
    logic        nrst;
    logic [31:0] i_ALUOut;
    logic [31:0] i_RTData;
    logic        i_MemRead;
    logic        i_MemWrite;
    logic        i_Mem2Reg;
    logic        i_RegWrite;
    logic [4:0]  i_RegAddrW;
    logic        i_Overflow;
    logic        o_stall;
    logic        o_RegWrite;
    logic        o_Mem2Reg;
    logic [4:0]  o_RegAddrW;
    logic [31:0] o_ALUOut;
    logic [31:0] o_MemData;
    logic        o_AddrErr;
    logic        o_BusErr;

    int total;
    int bad;

    mem_stage_if bus ();

    mem_stage #(.TIMEOUT(4)) dut (
        .clk        (clk),
        .nrst       (nrst),
        .i_ALUOut   (i_ALUOut),
        .i_RTData   (i_RTData),
        .i_MemRead  (i_MemRead),
        .i_MemWrite (i_MemWrite),
        .i_Mem2Reg  (i_Mem2Reg),
        .i_RegWrite (i_RegWrite),
        .i_RegAddrW (i_RegAddrW),
        .i_Overflow (i_Overflow),
        .dmem       (bus),
        .o_stall    (o_stall),
        .o_RegWrite (o_RegWrite),
        .o_Mem2Reg  (o_Mem2Reg),
        .o_RegAddrW (o_RegAddrW),
        .o_ALUOut   (o_ALUOut),
        .o_MemData  (o_MemData),
        .o_AddrErr  (o_AddrErr),
        .o_BusErr   (o_BusErr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic set_instr(input logic [31:0] alu, input logic [31:0] rt, input logic rd,
                             input logic wr, input logic rw, input logic [4:0] ra, input logic ov);
        i_ALUOut   = alu;
        i_RTData   = rt;
        i_MemRead  = rd;
        i_MemWrite = wr;
        i_Mem2Reg  = rd;
        i_RegWrite = rw;
        i_RegAddrW = ra;
        i_Overflow = ov;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        total = 0;
        bad   = 0;
        nrst  = 1'b0;
        bus.dmem_ack   = 1'b0;
        bus.dmem_rdata = 32'h0;
        set_instr(32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);

        // Reset values
        step(); step();
        #2;
        chk("rst_stall", 32'(o_stall), 32'd0);
        chk("rst_req", 32'(bus.dmem_req), 32'd0);
        chk("rst_we", 32'(bus.dmem_we), 32'd0);
        chk("rst_addr", bus.dmem_addr, 32'h0);
        chk("rst_wdata", bus.dmem_wdata, 32'h0);
        chk("rst_memdata", o_MemData, 32'h0);
        chk("rst_buserr", 32'(o_BusErr), 32'd0);
        step();
        nrst = 1'b1;

        // Load 0x10, ack on second BUSY cycle
        step();
        set_instr(32'h0000_0010, 32'h0, 1'b1, 1'b0, 1'b1, 5'd5, 1'b0);
        #2;
        chk("ld1_idle_stall", 32'(o_stall), 32'd1);
        chk("ld1_idle_req", 32'(bus.dmem_req), 32'd0);
        chk("ld1_aluout", o_ALUOut, 32'h0000_0010);
        chk("ld1_regaddr", 32'(o_RegAddrW), 32'd5);
        chk("ld1_mem2reg", 32'(o_Mem2Reg), 32'd1);
        step(); #2;
        chk("ld1_busy1_req", 32'(bus.dmem_req), 32'd1);
        chk("ld1_busy1_we", 32'(bus.dmem_we), 32'd0);
        chk("ld1_busy1_addr", bus.dmem_addr, 32'h0000_0010);
        chk("ld1_busy1_stall", 32'(o_stall), 32'd1);
        step();
        bus.dmem_ack = 1'b1; bus.dmem_rdata = 32'hDEAD_BEEF;
        #2;
        chk("ld1_busy2_req", 32'(bus.dmem_req), 32'd1);
        chk("ld1_busy2_stall", 32'(o_stall), 32'd1);
        step();
        bus.dmem_ack = 1'b0;
        #2;
        chk("ld1_done_stall", 32'(o_stall), 32'd0);
        chk("ld1_done_req", 32'(bus.dmem_req), 32'd0);
        chk("ld1_done_memdata", o_MemData, 32'hDEAD_BEEF);
        chk("ld1_done_regwrite", 32'(o_RegWrite), 32'd1);
        chk("ld1_done_buserr", 32'(o_BusErr), 32'd0);
        $display("txn load addr=00000010 data=%h", o_MemData);

        // Store 0x20 / 0x12345678, ack on first BUSY cycle
        step();
        set_instr(32'h0000_0020, 32'h1234_5678, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0);
        #2;
        chk("st_idle_stall", 32'(o_stall), 32'd1);
        step();
        bus.dmem_ack = 1'b1; bus.dmem_rdata = 32'hFFFF_0000;
        #2;
        chk("st_busy_req", 32'(bus.dmem_req), 32'd1);
        chk("st_busy_we", 32'(bus.dmem_we), 32'd1);
        chk("st_busy_addr", bus.dmem_addr, 32'h0000_0020);
        chk("st_busy_wdata", bus.dmem_wdata, 32'h1234_5678);
        step();
        bus.dmem_ack = 1'b0;
        #2;
        chk("st_done_stall", 32'(o_stall), 32'd0);
        chk("st_done_req", 32'(bus.dmem_req), 32'd0);
        chk("st_done_we", 32'(bus.dmem_we), 32'd0);
        chk("st_done_memdata", o_MemData, 32'hDEAD_BEEF);
        chk("st_done_regwrite", 32'(o_RegWrite), 32'd0);
        $display("txn store addr=00000020 data=12345678");

        // Misaligned load 0x13; ack in IDLE must be ignored
        step();
        set_instr(32'h0000_0013, 32'h0, 1'b1, 1'b0, 1'b1, 5'd6, 1'b0);
        bus.dmem_ack = 1'b1; bus.dmem_rdata = 32'h0000_0055;
        #2;
        chk("mis_addrerr", 32'(o_AddrErr), 32'd1);
        chk("mis_stall", 32'(o_stall), 32'd0);
        chk("mis_regwrite", 32'(o_RegWrite), 32'd0);
        step(); #2;
        chk("mis_req", 32'(bus.dmem_req), 32'd0);
        chk("mis_memdata", o_MemData, 32'hDEAD_BEEF);
        bus.dmem_ack = 1'b0;
        $display("txn misaligned load addr=00000013");

        // Load 0x40, no ack: abort after 4 BUSY cycles
        step();
        set_instr(32'h0000_0040, 32'h0, 1'b1, 1'b0, 1'b1, 5'd8, 1'b0);
        #2;
        chk("to_idle_stall", 32'(o_stall), 32'd1);
        for (int i = 0; i < 4; i++) begin
            step(); #2;
            chk($sformatf("to_busy%0d_req", i), 32'(bus.dmem_req), 32'd1);
            chk($sformatf("to_busy%0d_buserr", i), 32'(o_BusErr), 32'd0);
        end
        step(); #2;
        chk("to_done_buserr", 32'(o_BusErr), 32'd1);
        chk("to_done_memdata", o_MemData, 32'h0);
        chk("to_done_regwrite", 32'(o_RegWrite), 32'd0);
        chk("to_done_stall", 32'(o_stall), 32'd0);
        chk("to_done_req", 32'(bus.dmem_req), 32'd0);
        $display("txn timeout load addr=00000040");

        // Overflowed access: no request, no writeback
        step();
        set_instr(32'h0000_0050, 32'h0, 1'b1, 1'b0, 1'b1, 5'd9, 1'b1);
        #2;
        chk("ov_stall", 32'(o_stall), 32'd0);
        chk("ov_addrerr", 32'(o_AddrErr), 32'd0);
        chk("ov_regwrite", 32'(o_RegWrite), 32'd0);
        chk("ov_buserr", 32'(o_BusErr), 32'd0);
        step(); #2;
        chk("ov_req", 32'(bus.dmem_req), 32'd0);
        $display("txn overflow load addr=00000050");

        // Back-to-back loads 0x100 and 0x104
        step();
        set_instr(32'h0000_0100, 32'h0, 1'b1, 1'b0, 1'b1, 5'd7, 1'b0);
        #2;
        chk("bb1_idle_stall", 32'(o_stall), 32'd1);
        step();
        bus.dmem_ack = 1'b1; bus.dmem_rdata = 32'h0000_00A1;
        #2;
        chk("bb1_busy_addr", bus.dmem_addr, 32'h0000_0100);
        step();
        bus.dmem_ack = 1'b0;
        #2;
        chk("bb1_done_memdata", o_MemData, 32'h0000_00A1);
        chk("bb1_done_regwrite", 32'(o_RegWrite), 32'd1);
        $display("txn load addr=00000100 data=%h", o_MemData);
        step();
        set_instr(32'h0000_0104, 32'h0, 1'b1, 1'b0, 1'b1, 5'd8, 1'b0);
        #2;
        chk("bb2_idle_stall", 32'(o_stall), 32'd1);
        chk("bb2_idle_req", 32'(bus.dmem_req), 32'd0);
        step();
        bus.dmem_ack = 1'b1; bus.dmem_rdata = 32'h0000_00B2;
        #2;
        chk("bb2_busy_addr", bus.dmem_addr, 32'h0000_0104);
        step();
        bus.dmem_ack = 1'b0;
        #2;
        chk("bb2_done_memdata", o_MemData, 32'h0000_00B2);
        chk("bb2_done_stall", 32'(o_stall), 32'd0);
        $display("txn load addr=00000104 data=%h", o_MemData);

        // Reset during second BUSY cycle, late ack ignored
        step();
        set_instr(32'h0000_0200, 32'h0, 1'b1, 1'b0, 1'b1, 5'd3, 1'b0);
        step(); #2;
        chk("rb_busy1_req", 32'(bus.dmem_req), 32'd1);
        step(); #2;
        chk("rb_busy2_req", 32'(bus.dmem_req), 32'd1);
        nrst = 1'b0;
        #1;
        chk("rb_async_req", 32'(bus.dmem_req), 32'd0);
        chk("rb_async_stall", 32'(o_stall), 32'd0);
        chk("rb_async_addr", bus.dmem_addr, 32'h0);
        chk("rb_async_memdata", o_MemData, 32'h0);
        chk("rb_async_we", 32'(bus.dmem_we), 32'd0);
        step();
        bus.dmem_ack = 1'b1; bus.dmem_rdata = 32'h0000_0077;
        #2;
        chk("rb_ack_req", 32'(bus.dmem_req), 32'd0);
        step();
        set_instr(32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
        nrst = 1'b1;
        step(); #2;
        chk("rb_after_req", 32'(bus.dmem_req), 32'd0);
        chk("rb_after_stall", 32'(o_stall), 32'd0);
        chk("rb_after_memdata", o_MemData, 32'h0);
        chk("rb_after_buserr", 32'(o_BusErr), 32'd0);
        bus.dmem_ack = 1'b0;
        $display("txn reset during busy addr=00000200");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
